// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the RISC-V pipeline back end: the load funct3
// encodings and the writeback state type. The decoder, the LSU and the
// writeback unit all import this package, so an encoding lives in one place.
// ---------------------------------------------------------------------------
package riscv_pkg;

  // Load funct3 encodings. Bit 2 selects zero extension, bits [1:0] give the
  // log2 of the access size in bytes.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  // Writeback unit states: idle (accepting) or waiting on a load response.
  typedef enum logic {
    WB_IDLE     = 1'b0,
    WB_WAIT_MEM = 1'b1
  } wb_state_t;

endpackage : riscv_pkg

// File: rtl/riscv_load_align.sv
// ---------------------------------------------------------------------------
// riscv_load_align
// Purely combinational load lane selection and extension. Takes the naturally
// aligned memory word, picks the addressed byte/half/word/dword using the low
// address bits, and sign- or zero-extends it to XLEN. Also flags accesses
// that are misaligned or whose funct3 is not a legal load for this XLEN.
//
// Ports:
//   data   [XLEN-1:0] naturally aligned memory word holding the load
//   funct3 [2:0]      load funct3
//   offset [OFFW-1:0] byte offset of the load inside the word
//   value  [XLEN-1:0] aligned, extended load result (meaningless on fault)
//   fault             1 = misaligned access or illegal funct3
// ---------------------------------------------------------------------------
module riscv_load_align
  import riscv_pkg::*;
#(
  parameter int XLEN = 32,
  localparam int OFFW = $clog2(XLEN/8)
) (
  input  logic [XLEN-1:0] data,
  input  logic [2:0]      funct3,
  input  logic [OFFW-1:0] offset,
  output logic [XLEN-1:0] value,
  output logic            fault
);

  // Shift amount in bits: the byte offset times eight.
  logic [OFFW+2:0] w_shamt;
  logic [XLEN-1:0] w_shifted;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [31:0]     w_word;

  assign w_shamt   = {offset, 3'b000};
  assign w_shifted = data >> w_shamt;
  assign w_byte    = w_shifted[7:0];
  assign w_half    = w_shifted[15:0];
  assign w_word    = w_shifted[31:0];

  // Size casts do the extension: a signed operand widens with its sign bit,
  // an unsigned one with zeros. This keeps the code free of zero-width
  // replications when XLEN is 32.
  always_comb begin
    value = '0;
    fault = 1'b0;
    case (funct3)
      F3_LB: begin
        value = XLEN'($signed(w_byte));
      end
      F3_LH: begin
        value = XLEN'($signed(w_half));
        fault = offset[0];
      end
      F3_LW: begin
        value = XLEN'($signed(w_word));
        fault = (offset[1:0] != 2'b00);
      end
      F3_LD: begin
        value = w_shifted;
        fault = (XLEN == 32) || (offset != '0);
      end
      F3_LBU: begin
        value = XLEN'(w_byte);
      end
      F3_LHU: begin
        value = XLEN'(w_half);
        fault = offset[0];
      end
      F3_LWU: begin
        value = XLEN'(w_word);
        fault = (XLEN == 32) || (offset[1:0] != 2'b00);
      end
      default: begin
        // funct3 111 is not a load for any XLEN.
        value = '0;
        fault = 1'b1;
      end
    endcase
  end

endmodule : riscv_load_align

// File: rtl/riscv_writeback_unit.sv
// ---------------------------------------------------------------------------
// riscv_writeback_unit
// Writeback stage driving the rd write port of the register file. Retires
// one instruction per handshake: ALU results are written the next cycle,
// loads wait for the memory response, are aligned/extended, then written.
// Misaligned or illegal loads raise a one-cycle load_fault instead of a
// write. Every completed rd write bumps a wrapping retired counter.
//
// Ports:
//   clock, reset          clock and asynchronous active-high reset
//   in_valid / in_ready   retire handshake from execute/memory stage
//   in_is_load            result comes from memory rather than the ALU
//   in_rd_addr, in_rd_en  destination register and its write enable
//   in_alu_result         ALU result for non-load instructions
//   in_funct3, in_offset  load type and low address bits
//   mem_rsp_valid/_data   data memory response (naturally aligned word)
//   rd_addr, rd_enable_write, rd_data   register file write port
//   load_fault            one-cycle pulse on misaligned/illegal load
//   retired_count         number of completed rd writes (wraps)
// ---------------------------------------------------------------------------
module riscv_writeback_unit
  import riscv_pkg::*;
#(
  parameter int XLEN = 32,
  localparam int OFFW = $clog2(XLEN/8)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_is_load,
  input  logic [4:0]      in_rd_addr,
  input  logic            in_rd_en,
  input  logic [XLEN-1:0] in_alu_result,
  input  logic [2:0]      in_funct3,
  input  logic [OFFW-1:0] in_offset,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rsp_data,
  output logic [4:0]      rd_addr,
  output logic            rd_enable_write,
  output logic [XLEN-1:0] rd_data,
  output logic            load_fault,
  output logic [XLEN-1:0] retired_count
);

  wb_state_t       r_state;

  // Load context captured at the handshake, held while waiting on memory.
  logic [4:0]      r_pendRdAddr;
  logic            r_pendRdEn;
  logic [2:0]      r_pendFunct3;
  logic [OFFW-1:0] r_pendOffset;

  // Registered write port and status outputs.
  logic [4:0]      r_rdAddr;
  logic            r_rdWe;
  logic [XLEN-1:0] r_rdData;
  logic            r_loadFault;
  logic [XLEN-1:0] r_retiredCount;

  logic [XLEN-1:0] w_loadValue;
  logic            w_loadFault;
  logic            w_aluWrite;
  logic            w_loadWrite;

  // The aligner works on the captured load context; the memory data is only
  // consumed in the cycle the response is valid.
  riscv_load_align #(
    .XLEN(XLEN)
  ) u_align (
    .data  (mem_rsp_data),
    .funct3(r_pendFunct3),
    .offset(r_pendOffset),
    .value (w_loadValue),
    .fault (w_loadFault)
  );

  // Writes to x0 complete silently: they never reach the register file and
  // never count as retired writes.
  assign w_aluWrite  = in_rd_en && (in_rd_addr != 5'd0);
  assign w_loadWrite = r_pendRdEn && (r_pendRdAddr != 5'd0);

  assign in_ready        = (r_state == WB_IDLE);
  assign rd_addr         = r_rdAddr;
  assign rd_enable_write = r_rdWe;
  assign rd_data         = r_rdData;
  assign load_fault      = r_loadFault;
  assign retired_count   = r_retiredCount;

  // Writeback FSM with registered outputs. The write enable and fault flag
  // default low every cycle so each is a single-cycle pulse; address and
  // data only change when a new result is accepted. A response arriving
  // while idle is ignored, and a reset while waiting drops the load.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state        <= WB_IDLE;
      r_pendRdAddr   <= '0;
      r_pendRdEn     <= 1'b0;
      r_pendFunct3   <= '0;
      r_pendOffset   <= '0;
      r_rdAddr       <= '0;
      r_rdWe         <= 1'b0;
      r_rdData       <= '0;
      r_loadFault    <= 1'b0;
      r_retiredCount <= '0;
    end else begin
      r_rdWe      <= 1'b0;
      r_loadFault <= 1'b0;
      case (r_state)
        WB_IDLE: begin
          if (in_valid) begin
            if (in_is_load) begin
              r_pendRdAddr <= in_rd_addr;
              r_pendRdEn   <= in_rd_en;
              r_pendFunct3 <= in_funct3;
              r_pendOffset <= in_offset;
              r_state      <= WB_WAIT_MEM;
            end else begin
              r_rdAddr <= in_rd_addr;
              r_rdData <= in_alu_result;
              r_rdWe   <= w_aluWrite;
              if (w_aluWrite) begin
                r_retiredCount <= r_retiredCount + XLEN'(1);
              end
            end
          end
        end
        WB_WAIT_MEM: begin
          if (mem_rsp_valid) begin
            r_state <= WB_IDLE;
            if (w_loadFault) begin
              r_loadFault <= 1'b1;
            end else begin
              r_rdAddr <= r_pendRdAddr;
              r_rdData <= w_loadValue;
              r_rdWe   <= w_loadWrite;
              if (w_loadWrite) begin
                r_retiredCount <= r_retiredCount + XLEN'(1);
              end
            end
          end
        end
        default: begin
          r_state <= WB_IDLE;
        end
      endcase
    end
  end

endmodule : riscv_writeback_unit

// File: tb/tb_riscv_writeback_unit.sv
// ---------------------------------------------------------------------------
// tb_riscv_writeback_unit
// Scoreboard bench for the writeback unit. A 32-bit instance is driven with
// directed and random instructions; each expected register-file event is
// queued by the stimulus and popped by an independent monitor. A 64-bit
// instance covers doubleword and unsigned-word loads.
// ---------------------------------------------------------------------------
module tb_riscv_writeback_unit;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  // 32-bit instance signals
  logic        inValid = 1'b0;
  logic        inReady;
  logic        inIsLoad = 1'b0;
  logic [4:0]  inRdAddr = '0;
  logic        inRdEn = 1'b0;
  logic [31:0] inAluResult = '0;
  logic [2:0]  inFunct3 = '0;
  logic [1:0]  inOffset = '0;
  logic        memRspValid = 1'b0;
  logic [31:0] memRspData = '0;
  logic [4:0]  rdAddr;
  logic        rdWe;
  logic [31:0] rdData;
  logic        loadFault;
  logic [31:0] retiredCount;

  // 64-bit instance signals
  logic        inValid64 = 1'b0;
  logic        inReady64;
  logic [4:0]  inRdAddr64 = '0;
  logic [2:0]  inFunct364 = '0;
  logic [2:0]  inOffset64 = '0;
  logic        memRspValid64 = 1'b0;
  logic [63:0] memRspData64 = '0;
  logic [4:0]  rdAddr64;
  logic        rdWe64;
  logic [63:0] rdData64;
  logic        loadFault64;
  logic [63:0] retiredCount64;

  riscv_writeback_unit #(.XLEN(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .in_valid       (inValid),
    .in_ready       (inReady),
    .in_is_load     (inIsLoad),
    .in_rd_addr     (inRdAddr),
    .in_rd_en       (inRdEn),
    .in_alu_result  (inAluResult),
    .in_funct3      (inFunct3),
    .in_offset      (inOffset),
    .mem_rsp_valid  (memRspValid),
    .mem_rsp_data   (memRspData),
    .rd_addr        (rdAddr),
    .rd_enable_write(rdWe),
    .rd_data        (rdData),
    .load_fault     (loadFault),
    .retired_count  (retiredCount)
  );

  riscv_writeback_unit #(.XLEN(64)) dut64 (
    .clock          (clock),
    .reset          (reset),
    .in_valid       (inValid64),
    .in_ready       (inReady64),
    .in_is_load     (1'b1),
    .in_rd_addr     (inRdAddr64),
    .in_rd_en       (1'b1),
    .in_alu_result  (64'h0),
    .in_funct3      (inFunct364),
    .in_offset      (inOffset64),
    .mem_rsp_valid  (memRspValid64),
    .mem_rsp_data   (memRspData64),
    .rd_addr        (rdAddr64),
    .rd_enable_write(rdWe64),
    .rd_data        (rdData64),
    .load_fault     (loadFault64),
    .retired_count  (retiredCount64)
  );

  typedef struct {
    bit          isFault;
    logic [4:0]  addr;
    logic [63:0] data;
    logic [63:0] cnt;
  } exp_t;

  exp_t expQ[$];
  int   total = 0;
  int   bad = 0;
  int   modelCount = 0;
  int   modelCount64 = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Reference load semantics: size from funct3[1:0], unsigned from
  // funct3[2], alignment as offset modulo size, extension by masking.
  function automatic void refLoad(input logic [63:0] data, input logic [2:0] f3,
                                  input int off, input int xlen,
                                  output logic [63:0] val, output bit flt);
    int size;
    logic [63:0] mask;
    logic [63:0] raw;
    size = 1 << f3[1:0];
    flt  = (f3 == 3'd7) || (xlen == 32 && (f3 == 3'd3 || f3 == 3'd6)) || ((off % size) != 0);
    raw  = data >> (off * 8);
    if (size < 8) begin
      mask = (64'd1 << (size * 8)) - 64'd1;
      raw  = raw & mask;
      if (!f3[2] && raw[size*8-1]) raw = raw | ~mask;
    end
    if (xlen == 32) raw = raw & 64'h0000_0000_FFFF_FFFF;
    val = raw;
  endfunction

  // Monitor: every write or fault pulse must match the oldest expectation.
  always @(negedge clock) begin
    if (!reset && (rdWe || loadFault)) begin
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpectedEvent actual we=%0b fault=%0b addr=%0d required=none",
                 rdWe, loadFault, rdAddr);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("eventKind", {62'h0, rdWe, loadFault}, e.isFault ? 64'd1 : 64'd2);
        checkOutput("retiredCount", {32'h0, retiredCount}, e.cnt);
        if (!e.isFault) begin
          checkOutput("rdAddr", {59'h0, rdAddr}, {59'h0, e.addr});
          checkOutput("rdData", {32'h0, rdData}, e.data);
        end
      end
    end
  end

  // Issue one instruction to the 32-bit unit, queue what it must produce,
  // and for loads deliver the memory response after 'latency' idle cycles.
  task automatic applyStimulus(input bit isLoad, input logic [4:0] addr, input bit en,
                               input logic [31:0] alu, input logic [2:0] f3,
                               input logic [1:0] off, input logic [31:0] memData,
                               input int latency);
    int n;
    exp_t e;
    logic [63:0] v;
    bit f;
    n = 0;
    while (!inReady && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    if (n == 20) begin
      checkOutput("readyTimeout", {63'h0, inReady}, 64'd1);
      return;
    end
    inValid     = 1'b1;
    inIsLoad    = isLoad;
    inRdAddr    = addr;
    inRdEn      = en;
    inAluResult = alu;
    inFunct3    = f3;
    inOffset    = off;
    // A stray response while idle must be ignored.
    memRspValid = $urandom_range(0, 1);
    memRspData  = $urandom;
    @(posedge clock); #1;
    inValid     = 1'b0;
    memRspValid = 1'b0;
    if (!isLoad) begin
      checkOutput("readyAlu", {63'h0, inReady}, 64'd1);
      if (en && addr != 5'd0) begin
        modelCount++;
        e.isFault = 1'b0; e.addr = addr; e.data = {32'h0, alu}; e.cnt = modelCount;
        expQ.push_back(e);
      end
    end else begin
      for (int i = 0; i <= latency; i++) begin
        checkOutput("readyWait", {63'h0, inReady}, 64'd0);
        if (i < latency) begin
          @(posedge clock); #1;
        end
      end
      refLoad({32'h0, memData}, f3, int'(off), 32, v, f);
      if (f) begin
        e.isFault = 1'b1; e.addr = '0; e.data = '0; e.cnt = modelCount;
        expQ.push_back(e);
      end else if (en && addr != 5'd0) begin
        modelCount++;
        e.isFault = 1'b0; e.addr = addr; e.data = v; e.cnt = modelCount;
        expQ.push_back(e);
      end
      memRspValid = 1'b1;
      memRspData  = memData;
      @(posedge clock); #1;
      memRspValid = 1'b0;
      checkOutput("readyAfterLoad", {63'h0, inReady}, 64'd1);
    end
  endtask

  // One load through the 64-bit unit with a single-cycle memory latency.
  task automatic apply64(input logic [2:0] f3, input logic [2:0] off,
                         input logic [63:0] data, input logic [4:0] addr);
    logic [63:0] v;
    bit f;
    checkOutput("ready64", {63'h0, inReady64}, 64'd1);
    inValid64  = 1'b1;
    inRdAddr64 = addr;
    inFunct364 = f3;
    inOffset64 = off;
    @(posedge clock); #1;
    inValid64     = 1'b0;
    memRspValid64 = 1'b1;
    memRspData64  = data;
    @(posedge clock); #1;
    memRspValid64 = 1'b0;
    refLoad(data, f3, int'(off), 64, v, f);
    checkOutput("fault64", {63'h0, loadFault64}, {63'h0, f});
    checkOutput("we64", {63'h0, rdWe64}, {63'h0, (!f && addr != 5'd0)});
    if (!f && addr != 5'd0) begin
      modelCount64++;
      checkOutput("data64", rdData64, v);
      checkOutput("addr64", {59'h0, rdAddr64}, {59'h0, addr});
    end
    checkOutput("count64", retiredCount64, 64'(modelCount64));
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock); #1;

    // Reset state
    checkOutput("resetReady", {63'h0, inReady}, 64'd1);
    checkOutput("resetWe", {63'h0, rdWe}, 64'd0);
    checkOutput("resetAddr", {59'h0, rdAddr}, 64'd0);
    checkOutput("resetData", {32'h0, rdData}, 64'd0);
    checkOutput("resetFault", {63'h0, loadFault}, 64'd0);
    checkOutput("resetCount", {32'h0, retiredCount}, 64'd0);

    // ALU stream, including a write to x0 that must not count
    applyStimulus(1'b0, 5'd5, 1'b1, 32'h11, 3'd0, 2'd0, 32'h0, 0);
    applyStimulus(1'b0, 5'd6, 1'b1, 32'h22, 3'd0, 2'd0, 32'h0, 0);
    applyStimulus(1'b0, 5'd0, 1'b1, 32'h33, 3'd0, 2'd0, 32'h0, 0);
    @(posedge clock); #1;
    checkOutput("aluCount", {32'h0, retiredCount}, 64'd2);

    // Directed loads: LB sign, LHU/LH, misaligned LW, LD illegal at XLEN=32
    applyStimulus(1'b1, 5'd7, 1'b1, 32'h0, 3'b000, 2'd3, 32'h80AABBCC, 3);
    applyStimulus(1'b1, 5'd8, 1'b1, 32'h0, 3'b101, 2'd2, 32'h9ABC1234, 1);
    applyStimulus(1'b1, 5'd9, 1'b1, 32'h0, 3'b001, 2'd2, 32'h9ABC1234, 0);
    applyStimulus(1'b1, 5'd10, 1'b1, 32'h0, 3'b010, 2'd1, 32'hDEADBEEF, 2);
    applyStimulus(1'b1, 5'd11, 1'b1, 32'h0, 3'b011, 2'd0, 32'h89ABCDEF, 1);
    applyStimulus(1'b1, 5'd12, 1'b1, 32'h0, 3'b111, 2'd0, 32'h12345678, 0);
    @(posedge clock); #1;
    checkOutput("loadCount", {32'h0, retiredCount}, 64'(modelCount));

    // Reset while waiting on memory abandons the load
    inValid = 1'b1; inIsLoad = 1'b1; inRdAddr = 5'd13; inRdEn = 1'b1;
    inFunct3 = 3'b010; inOffset = 2'd0;
    @(posedge clock); #1;
    inValid = 1'b0;
    @(posedge clock); #1;
    checkOutput("readyPreReset", {63'h0, inReady}, 64'd0);
    checkOutput("queueDrained", 64'(expQ.size()), 64'd0);
    #2 reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    modelCount = 0;
    modelCount64 = 0;
    memRspValid = 1'b1;
    memRspData  = 32'hCAFEF00D;
    @(posedge clock); #1;
    memRspValid = 1'b0;
    @(posedge clock); #1;
    checkOutput("rstReady", {63'h0, inReady}, 64'd1);
    checkOutput("rstWe", {63'h0, rdWe}, 64'd0);
    checkOutput("rstAddr", {59'h0, rdAddr}, 64'd0);
    checkOutput("rstData", {32'h0, rdData}, 64'd0);
    checkOutput("rstFault", {63'h0, loadFault}, 64'd0);
    checkOutput("rstCount", {32'h0, retiredCount}, 64'd0);

    // Random mix of ALU and load instructions
    for (int k = 0; k < 200; k++) begin
      applyStimulus(1'($urandom_range(0, 1)), 5'($urandom), 1'($urandom_range(0, 3) != 0),
                    $urandom, 3'($urandom), 2'($urandom), $urandom, $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clock); #1;
      end
    end

    // 64-bit unit: doubleword and word forms
    apply64(3'b011, 3'd0, 64'h0123456789ABCDEF, 5'd3);
    apply64(3'b010, 3'd4, 64'h80000000_11223344, 5'd4);
    apply64(3'b110, 3'd4, 64'h80000000_11223344, 5'd5);
    apply64(3'b011, 3'd4, 64'h0123456789ABCDEF, 5'd6);
    for (int k = 0; k < 30; k++) begin
      apply64(3'($urandom), 3'($urandom), {$urandom, $urandom}, 5'($urandom));
    end

    repeat (3) @(posedge clock);
    #1;
    checkOutput("finalQueueEmpty", 64'(expQ.size()), 64'd0);
    checkOutput("finalCount", {32'h0, retiredCount}, 64'(modelCount));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_riscv_writeback_unit

// File: doc/riscv_writeback_unit.md
Name: riscv_writeback_unit

Overview:
- Writeback stage that produces the rd write port of the RISC-V register file (rd_addr, rd_enable_write, rd_data).
- Accepts one retiring instruction per handshake from the execute/memory stage. The result is either an ALU result or a pending load.
- For loads, waits for the data memory response, then aligns and sign/zero-extends it.
- Drives a single registered write per instruction and counts retired writes.

Parameters:
- XLEN, 32, register width; legal values 32 or 64.
- OFFW, $clog2(XLEN/8), width of the load byte-offset field (derived; not overridden).

Ports:
- clock, input, 1, the single clock.
- reset, input, 1, asynchronous, active-high reset.
- in_valid, input, 1, upstream has an instruction to retire.
- in_ready, output, 1, unit can accept an instruction this cycle.
- in_is_load, input, 1, 1 = result comes from memory, 0 = use in_alu_result.
- in_rd_addr, input, 5, destination register.
- in_rd_en, input, 1, instruction writes rd (0 for stores/branches).
- in_alu_result, input, XLEN, ALU result.
- in_funct3, input, 3, load funct3 (LB=000, LH=001, LW=010, LD=011, LBU=100, LHU=101, LWU=110).
- in_offset, input, OFFW, low address bits of the load.
- mem_rsp_valid, input, 1, load data valid this cycle.
- mem_rsp_data, input, XLEN, naturally aligned memory word containing the load.
- rd_addr, output, 5, to register file.
- rd_enable_write, output, 1, to register file.
- rd_data, output, XLEN, to register file.
- load_fault, output, 1, one-cycle pulse: misaligned or illegal load funct3.
- retired_count, output, XLEN, number of completed rd writes (wraps).

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE.
  - rd_addr=0, rd_enable_write=0, rd_data=0, load_fault=0, retired_count=0.
  - in_ready reflects IDLE, i.e. 1, once reset deasserts.
  - Reset mid-load abandons the pending load; no write occurs.
- State machine: IDLE, WAIT_MEM.
  - in_ready=1 in IDLE, 0 in WAIT_MEM (combinational from state).
- IDLE, handshake (in_valid & in_ready), in_is_load=0:
  - Next cycle: rd_enable_write = in_rd_en & (in_rd_addr!=0), rd_addr=in_rd_addr, rd_data=in_alu_result.
  - Stay in IDLE. Back-to-back ALU retirements are sustained at 1 per cycle.
- IDLE, handshake, in_is_load=1:
  - Capture rd_addr, rd_en, funct3 and offset; go to WAIT_MEM.
  - rd_enable_write=0 next cycle.
  - mem_rsp_valid is ignored while in IDLE; memory latency is at least 1 cycle.
- WAIT_MEM:
  - Hold until mem_rsp_valid.
  - On mem_rsp_valid, select the lane with base = offset*8:
    - byte = data[base+:8]; half = data[base+:16]; word = data[base+:32]; dword = full data.
  - Extend:
    - LB/LH/LW sign-extend to XLEN.
    - LBU/LHU/LWU zero-extend.
    - LD is a passthrough.
  - Alignment requirements:
    - half needs offset[0]=0.
    - word needs offset[1:0]=0.
    - dword needs offset=0.
  - Illegal when XLEN=32: LD, LWU, and funct3 111. Funct3 111 is illegal for any XLEN.
  - Next cycle, legal case: write as for the ALU path; return to IDLE.
  - Next cycle, misaligned or illegal case: rd_enable_write=0, load_fault=1 for one cycle; return to IDLE.
  - The unit accepts a new instruction starting the cycle after the response (state=IDLE).
- Output latency:
  - rd_* registered, driven exactly one cycle after the accepting event (handshake or mem response).
  - rd_enable_write is high for exactly one cycle per write. rd_addr and rd_data hold their last value otherwise.
- x0 rule: rd_enable_write is never asserted with rd_addr=0. Such instructions still complete but do not count.
- retired_count increments in the same cycle rd_enable_write is driven high (registered alongside it); it wraps modulo 2^XLEN.

Decomposition:
- Shared package riscv_pkg holds:
  - funct3 load encodings as localparams (F3_LB..F3_LWU).
  - Writeback state enum type (WB_IDLE, WB_WAIT_MEM).
  - Reused by the decoder and LSU.
- One sub-module, riscv_load_align: purely combinational, parameterised by XLEN.
  - Inputs: data, funct3, offset.
  - Outputs: value, fault.
  - The LSU reuses it for the store-side checks.

Test Plan:
- ALU stream: 3 consecutive handshakes (x5=0x11, x6=0x22, x0=0x33) -> writes x5=0x11 and x6=0x22 on consecutive cycles, no write for x0, retired_count=2, in_ready stays 1.
- LB sign: load x7 funct3=000 offset=3, response 0x80AABBCC after 4 cycles -> in_ready=0 during the wait, then x7=0xFFFFFF80, written exactly once.
- LHU/LH: offset=2, response 0x9ABC1234 -> LHU gives 0x00009ABC; LH gives 0xFFFF9ABC.
- Misaligned: LW offset=1 -> load_fault pulses one cycle, rd_enable_write stays 0, retired_count unchanged, unit returns to IDLE.
- Reset mid-load: assert reset in WAIT_MEM, then deliver mem_rsp_valid after release -> no write, in_ready=1, all outputs 0.
- XLEN=64: LD offset=0, response 0x0123456789ABCDEF -> full value written. With XLEN=32, the same funct3 -> load_fault.
